seg7_to_bcd_capture: RTL and testbench

- Reads a time-multiplexed, active-low 7-segment display bus (segments plus per-digit enables) and recovers the BCD digit shown at each position.
- Receiving end of the BCD-to-7-segment display path. Used on the board and in the bench to check what the processor drives onto the display.
- Filters glitches with a stability window, flags patterns that are not legal digits, and signals when a full set of digits has been captured.

---
 rtl/seg7_to_bcd_capture.sv | 85 ++++++++
 tb/tb_seg7_to_bcd_capture.sv | 115 +++++++++++
 2 files changed

// File: rtl/seg7_to_bcd_capture.sv
// seg7_to_bcd_capture: recovers BCD digits from a multiplexed active-low 7-segment bus
// Each digit must stay stable for STABLE_CYCLES samples before it is committed.
module seg7_to_bcd_capture #(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [6:0]            seg_in,
   input  logic [DIGITS-1:0]     dig_en_n,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [DIGITS-1:0]     digit_err,
   output logic                  frame_valid,
   output logic                  frame_err
);
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] SC = CW'(STABLE_CYCLES);
   logic [6:0]          seg_q;
   logic [DIGITS-1:0]   en_q, sel, sel_in, seen, seen_nxt, err_nxt;
   logic [4*DIGITS-1:0] bcd_nxt;
   logic [CW-1:0]       cnt;
   logic                done, legal_in, change, commit, bad, frame;
   logic [3:0]          code;
   assign sel      = ~en_q;
   assign sel_in   = ~dig_en_n;
   assign legal_in = sel_in != '0 && (sel_in & (sel_in - DIGITS'(1))) == '0;
   assign change   = {seg_in, dig_en_n} != {seg_q, en_q};
   // a nonzero count implies the held sample is legal
   assign commit   = cnt == SC && !done;
   assign frame    = commit && &seen_nxt;
   always_comb begin
      bad  = 1'b0;
      case (seg_q)
         7'b1000000: code = 4'd0;
         7'b1111001: code = 4'd1;
         7'b0100100: code = 4'd2;
         7'b0110000: code = 4'd3;
         7'b0011001: code = 4'd4;
         7'b0010010: code = 4'd5;
         7'b0000010: code = 4'd6;
         7'b1111000: code = 4'd7;
         7'b0000000: code = 4'd8;
         7'b0011000: code = 4'd9;
         7'b1111111: code = 4'hF;
         default: begin
            code = 4'hE;
            bad  = 1'b1;
         end
      endcase
   end
   always_comb begin
      bcd_nxt  = bcd_out;
      err_nxt  = digit_err;
      seen_nxt = seen;
      for (int i = 0; i < DIGITS; i++)
         if (commit && sel[i]) begin
            bcd_nxt[4*i +: 4] = code;
            err_nxt[i]        = bad;
            seen_nxt[i]       = 1'b1;
         end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_q       <= '1;
         en_q        <= '1;
         cnt         <= '0;
         done        <= 1'b0;
         seen        <= '0;
         bcd_out     <= '1;
         digit_err   <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         seg_q       <= seg_in;
         en_q        <= dig_en_n;
         cnt         <= change ? (legal_in ? CW'(1) : '0) : (cnt != '0 && cnt != SC ? cnt + CW'(1) : cnt);
         done        <= change ? 1'b0 : (commit ? 1'b1 : done);
         bcd_out     <= bcd_nxt;
         digit_err   <= err_nxt;
         frame_valid <= frame;
         seen        <= frame ? '0 : seen_nxt;
         if (frame) frame_err <= |err_nxt;
      end
   end
endmodule

// File: tb/tb_seg7_to_bcd_capture.sv
// tb_seg7_to_bcd_capture: directed vectors with a frame scoreboard
module tb_seg7_to_bcd_capture;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  seg_in = 7'h7F;
   logic [3:0]  dig_en_n = 4'hF;
   logic [15:0] bcd_out;
   logic [3:0]  digit_err;
   logic        frame_valid, frame_err;
   int          total = 0, bad = 0;
   logic [16:0] exp_q[$];
   logic [6:0]  pat[10];
   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [6:0] JUNK  = 7'b1010101;

   seg7_to_bcd_capture #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .seg_in(seg_in), .dig_en_n(dig_en_n),
      .bcd_out(bcd_out), .digit_err(digit_err),
      .frame_valid(frame_valid), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic hold(input logic [3:0] en, input logic [6:0] s, input int n);
      @(negedge clk);
      dig_en_n = en;
      seg_in   = s;
      repeat (n) @(posedge clk);
   endtask

   task automatic show(input int d, input logic [6:0] s);
      hold(~(4'b1 << d), s, 6);
   endtask

   // monitor: every frame_valid pulse must match the oldest expected frame
   always @(negedge clk) begin
      if (frame_valid) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL frame_unexpected: got bcd=%h err=%b expected no frame", bcd_out, frame_err);
         end else begin
            logic [16:0] e;
            e = exp_q.pop_front();
            if ({frame_err, bcd_out} !== e) begin
               bad++;
               $display("FAIL frame: got err=%b bcd=%h expected err=%b bcd=%h", frame_err, bcd_out, e[16], e[15:0]);
            end
         end
      end
   end

   initial begin
      pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      check("rst_bcd", 32'(bcd_out), 32'hFFFF);
      check("rst_err", 32'(digit_err), 32'h0);
      check("rst_fv", 32'(frame_valid), 32'h0);
      check("rst_ferr", 32'(frame_err), 32'h0);
      hold(4'hF, BLANK, 6);
      check("idle_bcd", 32'(bcd_out), 32'hFFFF);
      hold(4'b1110, pat[3], 4);
      @(negedge clk);
      check("latency_before", 32'(bcd_out[3:0]), 32'hF);
      hold(4'b1110, pat[3], 1);
      @(negedge clk);
      check("latency_commit", 32'(bcd_out[3:0]), 32'h3);
      check("latency_err", 32'(digit_err[0]), 32'h0);
      hold(4'b1110, pat[3], 8);
      hold(4'b1110, pat[1], 3);
      hold(4'hF, BLANK, 3);
      @(negedge clk);
      check("glitch_ignored", 32'(bcd_out[3:0]), 32'h3);
      exp_q.push_back({1'b0, 16'hF921});
      show(0, pat[1]); show(1, pat[2]); show(2, pat[9]); show(3, BLANK);
      hold(4'hF, BLANK, 3);
      check("scan_bcd", 32'(bcd_out), 32'hF921);
      check("scan_err", 32'(digit_err), 32'h0);
      exp_q.push_back({1'b1, 16'h7E54});
      show(0, pat[4]); show(1, pat[5]); show(2, JUNK); show(3, pat[7]);
      hold(4'hF, BLANK, 3);
      check("illegal_err", 32'(digit_err), 32'b0100);
      check("illegal_ferr", 32'(frame_err), 32'h1);
      hold(4'b1100, pat[8], 10);
      hold(4'hF, BLANK, 3);
      check("multi_en_bcd", 32'(bcd_out), 32'h7E54);
      check("multi_en_err", 32'(digit_err), 32'b0100);
      show(0, pat[6]); show(1, pat[8]);
      @(negedge clk);
      check("partial_bcd", 32'(bcd_out[7:0]), 32'h86);
      hold(4'b1011, pat[0], 2);
      #2 rst = 1'b1;
      #1;
      check("midrst_bcd", 32'(bcd_out), 32'hFFFF);
      check("midrst_err", 32'(digit_err), 32'h0);
      check("midrst_ferr", 32'(frame_err), 32'h0);
      @(negedge clk) rst = 1'b0;
      exp_q.push_back({1'b0, 16'h3210});
      show(0, pat[0]); show(1, pat[1]); show(2, pat[2]); show(3, pat[3]);
      hold(4'hF, BLANK, 4);
      check("frames_pending", 32'(exp_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
